// File: rtl/wave_hit_scorer.sv
// wave_hit_scorer
//   Sits in front of the wave-enemy sprite block. It detects when a bullet
//   pixel and an opaque enemy pixel overlap, and latches that as a hit
//   until the enemy dies. It also counts kills (4-digit BCD score) and
//   escaped enemies, raises a game-over request, and derives the wave
//   descent divisor from the current level.
//
//   Optional build macro: STREAK_BONUS_EN
//     When defined, each kill made while four or more consecutive kills
//     have already been scored adds 2 to the score instead of 1.
//
// Ports
//   clk            system clock
//   rst            synchronous, active-high reset
//   pix_en         pixel-rate enable; overlap is sampled only when high
//   game_start_on  title screen showing
//   game_over_on   game-over screen showing
//   pause          game paused
//   b_on           pixel is inside a live bullet
//   e_w_on         pixel is an opaque wave-enemy pixel
//   is_active      wave enemy alive
//   hit_w_enemy    hit flag to the enemy, held until the enemy dies
//   kill_pulse     one-cycle strobe per counted kill
//   score          4-digit BCD kill score (saturates at 9999)
//   misses         escaped-enemy count (saturates at MAX_MISSES)
//   level          current level (saturates at MAX_LEVEL)
//   wave_speed     enemy speed divisor, clk ticks per pixel step
//   game_over_req  sticky request to enter the game-over screen
//
// state  | meaning
// IDLE   | title / waiting; counters frozen for display
// PLAY   | game running; hits latched, kills and escapes counted
// PAUSED | game paused; no new hits, enemy deaths still counted
// OVER   | game-over screen; counters frozen for display

module wave_hit_scorer #(
    parameter logic [23:0] BASE_SPEED      = 24'd400000,
    parameter logic [23:0] SPEED_STEP      = 24'd40000,
    parameter logic [23:0] MIN_SPEED       = 24'd80000,
    parameter int          KILLS_PER_LEVEL = 8,
    parameter int          MAX_LEVEL       = 8,
    parameter int          MAX_MISSES      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        game_start_on,
    input  logic        game_over_on,
    input  logic        pause,
    input  logic        b_on,
    input  logic        e_w_on,
    input  logic        is_active,
    output logic        hit_w_enemy,
    output logic        kill_pulse,
    output logic [15:0] score,
    output logic [1:0]  misses,
    output logic [3:0]  level,
    output logic [23:0] wave_speed,
    output logic        game_over_req
);

    typedef enum logic [1:0] {IDLE, PLAY, PAUSED, OVER} state_t;

    localparam logic [7:0] KILLS_PER_LEVEL_W = 8'(KILLS_PER_LEVEL);
    localparam logic [7:0] MAX_LEVEL_W       = 8'(MAX_LEVEL);
    localparam logic [1:0] MAX_MISSES_W      = 2'(MAX_MISSES);

    state_t      state;
    state_t      state_nxt;
    logic        is_active_d;
    logic [7:0]  kills;
    logic [7:0]  kills_inc;
    logic [7:0]  lvl_quot;
    logic [3:0]  level_inc;
    logic [1:0]  misses_inc;
    logic [1:0]  score_inc;
    logic [23:0] speed_red;
    logic [23:0] speed_calc;
    logic        start_play;
    logic        fall;
    logic        kill_evt;
    logic        escape_evt;
    logic        overlap;

    // Add 1 or 2 to a 4-digit BCD value, clamping at 9999 when the top
    // digit would carry out.
    function automatic logic [15:0] bcd_add(input logic [15:0] val, input logic [1:0] inc);
        logic [4:0]  d;
        logic [1:0]  c;
        logic [15:0] r;
        c = inc;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, val[i*4 +: 4]} + {3'b000, c};
            if (d > 5'd9) begin
                r[i*4 +: 4] = 4'(d - 5'd10);
                c           = 2'd1;
            end else begin
                r[i*4 +: 4] = d[3:0];
                c           = 2'd0;
            end
        end
        if (c != 2'd0) r = 16'h9999;
        return r;
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!game_start_on && !game_over_on) state_nxt = PLAY;
            PLAY:    if (game_over_req || game_over_on)   state_nxt = OVER;
                     else if (pause)                      state_nxt = PAUSED;
            PAUSED:  if (!pause)                          state_nxt = PLAY;
            OVER:    if (game_start_on)                   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    assign start_play = (state == IDLE) && (state_nxt == PLAY);
    // Deaths are still counted while paused so an enemy that leaves the
    // screen during a pause is not lost.
    assign fall       = ((state == PLAY) || (state == PAUSED)) && is_active_d && !is_active;
    assign kill_evt   = fall && hit_w_enemy;
    assign escape_evt = fall && !hit_w_enemy;
    assign overlap    = (state == PLAY) && pix_en && b_on && e_w_on && is_active && !hit_w_enemy;

    assign kills_inc  = (kills == 8'hFF) ? kills : kills + 8'd1;
    assign lvl_quot   = kills_inc / KILLS_PER_LEVEL_W;
    assign level_inc  = (lvl_quot > MAX_LEVEL_W) ? MAX_LEVEL_W[3:0] : lvl_quot[3:0];
    assign misses_inc = (misses == MAX_MISSES_W) ? misses : misses + 2'd1;

    // Compare first so the subtraction can never wrap below zero.
    assign speed_red  = 24'(level) * SPEED_STEP;
    assign speed_calc = ((speed_red < BASE_SPEED) && ((BASE_SPEED - speed_red) > MIN_SPEED))
                        ? (BASE_SPEED - speed_red) : MIN_SPEED;

`ifdef STREAK_BONUS_EN
    logic [2:0] streak;

    assign score_inc = (streak >= 3'd4) ? 2'd2 : 2'd1;

    always_ff @(posedge clk) begin
        if (rst)                             streak <= '0;
        else if (start_play || escape_evt)   streak <= '0;
        else if (kill_evt && streak != 3'd7) streak <= streak + 3'd1;
    end
`else
    assign score_inc = 2'd1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            is_active_d   <= 1'b0;
            hit_w_enemy   <= 1'b0;
            kill_pulse    <= 1'b0;
            score         <= '0;
            misses        <= '0;
            level         <= '0;
            kills         <= '0;
            wave_speed    <= BASE_SPEED;
            game_over_req <= 1'b0;
        end else begin
            is_active_d <= is_active;
            kill_pulse  <= kill_evt;
            wave_speed  <= speed_calc;

            if (!is_active)   hit_w_enemy <= 1'b0;
            else if (overlap) hit_w_enemy <= 1'b1;

            if (start_play) begin
                score         <= '0;
                misses        <= '0;
                level         <= '0;
                kills         <= '0;
                game_over_req <= 1'b0;
            end else if (kill_evt) begin
                score <= bcd_add(score, score_inc);
                kills <= kills_inc;
                level <= level_inc;
            end else if (escape_evt) begin
                misses <= misses_inc;
                if (misses_inc == MAX_MISSES_W) game_over_req <= 1'b1;
            end
        end
    end

endmodule

// File: doc/wave_hit_scorer.md
Name: wave_hit_scorer

Overview:
- Sits directly upstream of the wave-enemy sprite block in the shooter game.
- Detects bullet/enemy pixel overlap and drives the enemy's hit input, which is held until the enemy dies.
- Counts kills in BCD, counts enemies that escape, and raises a game-over request.
- Computes the enemy's descent divisor (wave speed) from the kill count.

Parameters:
- BASE_SPEED, 24'd400000: wave speed at level 0 (clk ticks per pixel step).
- SPEED_STEP, 24'd40000: speed-divisor reduction per level.
- MIN_SPEED, 24'd80000: floor for the wave speed output.
- KILLS_PER_LEVEL, 8: kills needed to advance one level.
- MAX_LEVEL, 8: level saturates at this value.
- MAX_MISSES, 3: number of escaped enemies that triggers game over.

Ports:
- clk  in  1  system clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- pix_en  in  1  pixel-rate enable; overlap is sampled only when high.
- game_start_on  in  1  title screen showing.
- game_over_on  in  1  game-over screen showing.
- pause  in  1  game paused.
- b_on  in  1  current pixel is inside a live bullet.
- e_w_on  in  1  current pixel is an opaque wave-enemy pixel.
- is_active  in  1  wave enemy alive.
- hit_w_enemy  out  1  hit flag to the enemy; held until the enemy dies.
- kill_pulse  out  1  one-cycle strobe for each counted kill.
- score  out  16  4-digit BCD kill score.
- misses  out  2  escaped-enemy count.
- level  out  4  current level.
- wave_speed  out  24  enemy speed divisor.
- game_over_req  out  1  sticky request to enter the game-over screen.

Behaviour:
- Reset values: hit_w_enemy=0, kill_pulse=0, score=16'h0000, misses=0, level=0, wave_speed=BASE_SPEED, game_over_req=0, FSM=IDLE, is_active_d=0.
- FSM states and transitions:
  - IDLE → PLAY when game_start_on=0 and game_over_on=0. Entering PLAY from IDLE clears score, misses, level, streak and game_over_req.
  - PLAY → PAUSED when pause=1. PAUSED → PLAY when pause=0.
  - PLAY → OVER when game_over_req is set, or when game_over_on=1.
  - OVER → IDLE when game_start_on=1.
  - Any state → IDLE on rst.
- Hit detection: valid in PLAY only.
  - Condition: pix_en & b_on & e_w_on & is_active & !hit_w_enemy.
  - Latency: hit_w_enemy rises on the next clk edge (1 cycle).
  - hit_w_enemy stays high until is_active is sampled low, then clears that same edge.
  - Repeat overlaps while the flag is high are ignored.
- is_active_d is is_active registered each cycle. The fall event is is_active_d=1 and is_active=0, and is evaluated in PLAY and PAUSED.
- On a fall with hit_w_enemy=1 (kill):
  - kill_pulse=1 for exactly one cycle.
  - score += 1 in BCD with per-digit carry; saturates at 16'h9999.
  - Internal kill counter (8-bit) increments.
  - level = min(kills / KILLS_PER_LEVEL, MAX_LEVEL).
- On a fall with hit_w_enemy=0 (escape):
  - misses += 1, saturating at MAX_MISSES.
  - Reaching MAX_MISSES sets game_over_req on the same edge.
- Simultaneous overlap and fall in one cycle: the fall wins, counted using the pre-edge hit flag; no new hit is latched.
- wave_speed is registered, 1 cycle after the level changes: max(BASE_SPEED − level*SPEED_STEP, MIN_SPEED). The subtraction must not underflow; compare before subtracting.
- In IDLE and OVER: no hits latched and no counters change; score and level hold for display.
- rst mid-game returns every output to its reset value on the next edge.

Optional Feature:
- Macro: STREAK_BONUS_EN.
- Defined:
  - A 3-bit streak counter counts consecutive kills; it clears on an escape and on entry to PLAY.
  - Once the streak is ≥4 before the current kill, that kill adds 2 to score (BCD, saturating at 9999).
  - The internal kill counter still adds 1.
- Undefined: streak logic is absent; every kill adds exactly 1.

Test Plan:
- Reset then release with game_start_on=0 → FSM enters PLAY; score=0000, wave_speed=400000, hit_w_enemy=0.
- One-cycle overlap (pix_en=b_on=e_w_on=is_active=1) → hit_w_enemy=1 next cycle. Drop is_active → hit_w_enemy=0, kill_pulse=1 for one cycle, score=0001.
- Drive 8 kills → level=1, wave_speed=360000. Drive 80 kills → level=8, wave_speed=80000 (floor applied).
- Three is_active falls without overlap → misses=3 on the third, game_over_req=1, FSM=OVER; further overlaps leave score unchanged.
- Preload score to 9999, then one kill → score stays 16'h9999; kill_pulse still fires.
- pause=1 while overlap is asserted → no hit latched. With STREAK_BONUS_EN defined and 4 prior kills, the 5th kill raises score from 0004 to 0006.
